ps2_frame_rx: RTL and testbench
===============================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of received-byte entries (power of two, min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 SHALL have port out_ready  input  1  consumer pop request.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_data  output  8  FIFO head scan-code byte.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse per discarded frame.
REQ-012 SHALL have port overflow  output  1  sticky flag, set on a byte dropped because FIFO was full.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; falling edge = previous synced clk 1, current 0.
REQ-014 SHALL sample synced ps2_data only in the cycle a falling edge is detected.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: edge with data 0 -> DATA, bit index 0; edge with data 1 -> stay IDLE, no error.
REQ-017 DATA: shift 8 bits LSB-first; after 8th edge -> PARITY.
REQ-018 PARITY: capture parity bit -> STOP; frame is valid only if XOR of 8 data bits and parity bit = 1 (odd parity).
REQ-019 STOP: on edge, if stop bit 1 and parity good -> push byte, else pulse frame_err; -> IDLE in both cases.
REQ-020 SHALL reset timeout counter on every detected edge and hold it at 0 in IDLE.
REQ-021 SHALL, outside IDLE, on counter reaching TIMEOUT_CYCLES-1: discard partial frame, pulse frame_err, -> IDLE next cycle.
REQ-022 out_valid SHALL rise on the cycle after the push cycle when FIFO was empty.
REQ-023 Pop SHALL occur on a cycle with out_valid=1 and out_ready=1; out_data presents next entry (or holds last value if now empty) on the following cycle.
REQ-024 out_ready with out_valid=0 SHALL be ignored.
REQ-025 Push when full and no pop SHALL drop the byte, set overflow, leave FIFO contents unchanged.
REQ-026 Simultaneous push and pop when full SHALL both take effect; count unchanged; overflow not set.
REQ-027 Simultaneous push and pop when non-empty, non-full SHALL leave count unchanged and preserve order.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 overflow SHALL remain 1 until rst.

Reset
REQ-030 On rst: state IDLE, bit index 0, timeout counter 0, synchronizer flops 1, FIFO pointers 0.
REQ-031 On rst: out_valid 0, out_data 8'h00, fifo_count 0, frame_err 0, overflow 0.
REQ-032 rst mid-frame SHALL abandon the frame without a frame_err pulse.

Structure
REQ-033 Package ps2_pkg SHALL hold the rx state enum, FIFO_DEPTH default and TIMEOUT_CYCLES default.
REQ-034 FIFO SHALL be one sub-module, ps2_byte_fifo (synchronous, registered output).

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> out_valid=1, out_data=0x1C, fifo_count=1, frame_err never pulses.
REQ-036 Frames 0xF0 then 0x1C, out_ready=0 -> fifo_count=2; popping yields 0xF0 then 0x1C; out_valid then 0.
REQ-037 Frame 0x1C with parity 1 -> exactly one frame_err pulse, fifo_count stays 0.
REQ-038 Nine frames 0x01..0x09, out_ready=0 -> fifo_count=8, overflow=1; pops yield 0x01..0x08; with FIFO full, push plus pop on the same cycle -> count stays 8.
REQ-039 Stop clocking after 4 data bits, wait TIMEOUT_CYCLES -> one frame_err pulse, state IDLE; next frame 0x29 is received correctly.
REQ-040 Assert rst after 5 data bits -> all outputs at reset values, no frame_err; next frame 0x5A gives out_data=0x5A.

Source files
------------

// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module  : ps2_pkg
// Brief   : Shared receive-state encoding and parameter defaults for the PS/2 rx.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

    localparam int c_FIFO_DEPTH     = 8;
    localparam int c_TIMEOUT_CYCLES = 10000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Odd parity: the eight data bits plus the parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
//------------------------------------------------------------------------------
// Module  : ps2_byte_fifo
// Brief   : Synchronous byte FIFO with a registered head output and sticky overflow.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop_req,
    output logic                     o_valid,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     c_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     c_ONE  = (AW + 1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_data;
    logic          r_overflow;

    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic [AW-1:0] w_rd_next;

    assign w_pop     = i_pop_req && (r_count != '0);
    assign w_full    = (r_count == c_FULL);
    assign w_wr      = i_push && (!w_full || w_pop);
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            // Head register: next stored entry after a pop, or the incoming byte
            // when it becomes the only entry.
            if (w_pop) begin
                if (r_count > c_ONE) begin
                    r_data <= r_mem[w_rd_next];
                end else if (w_wr) begin
                    r_data <= i_push_data;
                end
            end else if (w_wr && (r_count == '0)) begin
                r_data <= i_push_data;
            end
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_data     = r_data;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : ps2_frame_rx
// Brief   : PS/2 device-to-host frame receiver with timeout and scan-code FIFO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = c_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int              TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   c_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_clk_prev;
    logic          r_data_meta;
    logic          r_data_sync;

    rx_state_t     r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic          r_parity;
    logic [TW-1:0] r_timer;
    logic          r_frame_err;

    rx_state_t     w_state_nxt;
    logic [7:0]    w_shift_nxt;
    logic [2:0]    w_idx_nxt;
    logic          w_parity_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_push;
    logic          w_frame_err;
    logic          w_fall;

    assign w_fall = r_clk_prev && !r_clk_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_state     <= ST_IDLE;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_parity    <= 1'b0;
            r_timer     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_parity    <= w_parity_nxt;
            r_timer     <= w_timer_nxt;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_bit_idx;
        w_parity_nxt = r_parity;
        w_timer_nxt  = '0;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;

        if ((r_state != ST_IDLE) && !w_fall) begin
            w_timer_nxt = r_timer + 1'b1;
        end

        // A stalled partial frame is dropped; a real edge always wins over the timeout.
        if ((r_state != ST_IDLE) && !w_fall && (r_timer == c_TIMEOUT_LAST)) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 3'd0;
            w_timer_nxt = '0;
            w_frame_err = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_data_sync) begin
                        w_state_nxt = ST_DATA;
                        w_idx_nxt   = 3'd0;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt = {r_data_sync, r_shift[7:1]};
                    w_idx_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_parity_nxt = r_data_sync;
                    w_state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    if (r_data_sync && odd_parity_ok(r_shift, r_parity)) begin
                        w_push = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop_req   (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_count     (fifo_count),
        .o_overflow  (overflow)
    );

    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_ps2_frame_rx
// Brief   : Self-checking bench for ps2_frame_rx: vector table, corner sequences, random traffic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_frame_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int HALF  = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      ps2_clk;
    logic                      ps2_data;
    logic                      out_ready;
    logic                      out_valid;
    logic [7:0]                out_data;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      frame_err;
    logic                      overflow;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    ps2_frame_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (!rst && frame_err === 1'b1) err_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One PS/2 bit; with pop_here, out_ready is held for exactly the cycle the
    // falling edge is seen through the two-flop synchronizer.
    task automatic send_bit(input logic b, input bit pop_here);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_here) begin
            repeat (2) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit pop_on_stop);
        logic p;
        p = (~^d) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        send_bit(~bad_stop, pop_on_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit         is_pop;
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_cnt;
        logic [7:0] exp_head;
        int         exp_errs;
    } vec_t;

    vec_t       vt[10];
    int         base;
    logic [7:0] q[$];
    bit         ovf_m;
    int         errs_m;

    initial begin
        vt[0] = '{0, 8'h1C, 0, 0, 1, 8'h1C, 0};
        vt[1] = '{1, 8'h00, 0, 0, 0, 8'h1C, 0};
        vt[2] = '{0, 8'hF0, 0, 0, 1, 8'hF0, 0};
        vt[3] = '{0, 8'h1C, 0, 0, 2, 8'hF0, 0};
        vt[4] = '{1, 8'h00, 0, 0, 1, 8'h1C, 0};
        vt[5] = '{1, 8'h00, 0, 0, 0, 8'h1C, 0};
        vt[6] = '{0, 8'h1C, 1, 0, 0, 8'h1C, 1};
        vt[7] = '{0, 8'h55, 0, 1, 0, 8'h1C, 2};
        vt[8] = '{0, 8'h00, 0, 0, 1, 8'h00, 2};
        vt[9] = '{1, 8'h00, 0, 0, 0, 8'h00, 2};

        // Reset values
        do_reset();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 8'h00);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overflow", overflow, 0);

        // Vector table
        base = err_pulses;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].is_pop) pop_one();
            else send_frame(vt[i].data, vt[i].bad_par, vt[i].bad_stop, 1'b0);
            chk($sformatf("vec%0d count", i), fifo_count, vt[i].exp_cnt);
            chk($sformatf("vec%0d valid", i), out_valid, (vt[i].exp_cnt != 0));
            chk($sformatf("vec%0d head", i), out_data, vt[i].exp_head);
            chk($sformatf("vec%0d errs", i), err_pulses - base, vt[i].exp_errs);
        end

        // Nine frames into an eight-deep FIFO
        do_reset();
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
        chk("ovfA count", fifo_count, 8);
        chk("ovfA overflow", overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovfA pop%0d head", k), out_data, k);
            pop_one();
        end
        chk("ovfA drained valid", out_valid, 0);
        chk("ovfA drained count", fifo_count, 0);
        chk("ovfA overflow sticky", overflow, 1);

        // Push and pop on the same cycle while full
        do_reset();
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
        send_frame(8'h09, 1'b0, 1'b0, 1'b1);
        chk("full pushpop count", fifo_count, 8);
        chk("full pushpop overflow", overflow, 0);
        chk("full pushpop head", out_data, 8'h02);
        send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
        chk("full push overflow", overflow, 1);
        chk("full push count", fifo_count, 8);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("ovfB pop%0d head", k), out_data, k);
            pop_one();
        end
        chk("ovfB drained valid", out_valid, 0);

        // Reset in the middle of a frame (overflow is still set here)
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        chk("pre-rst count", fifo_count, 1);
        base = err_pulses;
        send_partial(5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 8'h00);
        chk("midrst fifo_count", fifo_count, 0);
        chk("midrst frame_err", frame_err, 0);
        chk("midrst overflow", overflow, 0);
        chk("midrst no err", err_pulses - base, 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("after rst head", out_data, 8'h5A);
        chk("after rst count", fifo_count, 1);
        chk("after rst errs", err_pulses - base, 0);

        // Timeout on a stalled frame
        do_reset();
        base = err_pulses;
        send_partial(4);
        chk("stall no early err", err_pulses - base, 0);
        repeat (TO + 20) @(negedge clk);
        chk("timeout err pulses", err_pulses - base, 1);
        chk("timeout count", fifo_count, 0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        chk("post-timeout head", out_data, 8'h29);
        chk("post-timeout count", fifo_count, 1);
        chk("post-timeout errs", err_pulses - base, 1);

        // Random traffic against a queue model
        do_reset();
        q.delete();
        ovf_m  = 1'b0;
        errs_m = 0;
        base   = err_pulses;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 3) begin
                pop_one();
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                logic [7:0] d;
                bit bp, bs, pos;
                d   = 8'($urandom);
                bp  = ($urandom_range(0, 7) == 0);
                bs  = ($urandom_range(0, 7) == 0);
                pos = ($urandom_range(0, 2) == 0);
                send_frame(d, bp, bs, pos);
                if (pos && q.size() > 0) void'(q.pop_front());
                if (bp || bs) errs_m++;
                else if (q.size() < DEPTH) q.push_back(d);
                else ovf_m = 1'b1;
            end
            chk($sformatf("rnd%0d count", n), fifo_count, q.size());
            chk($sformatf("rnd%0d valid", n), out_valid, (q.size() != 0));
            chk($sformatf("rnd%0d overflow", n), overflow, ovf_m);
            chk($sformatf("rnd%0d errs", n), err_pulses - base, errs_m);
            if (q.size() > 0) chk($sformatf("rnd%0d head", n), out_data, q[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
